// File: rtl/elevator_ctrl_if.sv
// Call, display and status signals between the elevator controller and its floor panel.
// door_hold exists only when ELEV_DOOR_HOLD_EN is defined.
interface elevator_ctrl_if;
  logic [2:0] req;
  logic [3:0] Disp_1;
  logic [3:0] Disp_2;
  logic       door_open;
  logic       moving_up;
  logic       moving_down;
  logic [2:0] pending;
`ifdef ELEV_DOOR_HOLD_EN
  logic       door_hold;
`endif

  modport master (
`ifdef ELEV_DOOR_HOLD_EN
    output door_hold,
`endif
    output req,
    input  Disp_1, Disp_2, door_open, moving_up, moving_down, pending
  );

  modport slave (
`ifdef ELEV_DOOR_HOLD_EN
    input  door_hold,
`endif
    input  req,
    output Disp_1, Disp_2, door_open, moving_up, moving_down, pending
  );
endinterface

// File: rtl/elevator_ctrl.sv
// Three-floor elevator controller: latches calls, serves them SCAN-style, times travel and door dwell.
// Define ELEV_DOOR_HOLD_EN to add the door_hold input that freezes the door timer.
module elevator_ctrl #(
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3
) (
  input  logic           new_clock,
  input  logic           rst_n,
  elevator_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_e;

  typedef struct packed {
    state_e st;
    logic   up;
  } plan_t;

  localparam logic [3:0] TRAVEL_LAST = 4'(TRAVEL_TICKS - 1);
  localparam logic [3:0] DOOR_LAST   = 4'(DOOR_TICKS - 1);

  state_e     state_q, state_d;
  logic [1:0] floor_q, floor_d;
  logic [1:0] next_floor_q, next_floor_d;
  logic [2:0] pending_q, pending_d;
  logic       dir_up_q, dir_up_d;
  logic [3:0] cnt_q, cnt_d;
  logic       door_open_q, moving_up_q, moving_down_q;
  logic       arrive, restart, hold, decide;
  logic [2:0] clr;
  plan_t      decision;

  function automatic logic [2:0] floor_bit(input logic [1:0] f);
    case (f)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] above(input logic [1:0] f);
    case (f)
      2'd0:    return 3'b110;
      2'd1:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] below(input logic [1:0] f);
    case (f)
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  // Current floor beats calls ahead, which beat calls behind; nothing at the
  // ends of the shaft is ever "ahead", so the car cannot run off floor 0..2.
  function automatic plan_t plan(input logic [2:0] p, input logic [1:0] f, input logic up);
    plan_t      r;
    logic [2:0] ahead_m, behind_m;
    ahead_m  = up ? above(f) : below(f);
    behind_m = up ? below(f) : above(f);
    r.st = IDLE;
    r.up = up;
    if (|(p & floor_bit(f))) begin
      r.st = DOOR_OPEN;
    end else if (|(p & ahead_m)) begin
      r.st = up ? MOVE_UP : MOVE_DOWN;
    end else if (|(p & behind_m)) begin
      r.up = ~up;
      r.st = up ? MOVE_DOWN : MOVE_UP;
    end
    return r;
  endfunction

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = bus.door_hold;
`else
  assign hold = 1'b0;
`endif

  assign arrive   = (state_q == MOVE_UP || state_q == MOVE_DOWN) && (cnt_q == TRAVEL_LAST);
  assign floor_d  = !arrive ? floor_q :
                    (state_q == MOVE_UP) ? floor_q + 2'd1 : floor_q - 2'd1;
  assign decision = plan(pending_q, floor_d, dir_up_q);
  assign restart  = (state_q == DOOR_OPEN) && |(bus.req & floor_bit(floor_q));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    dir_up_d = dir_up_q;
    cnt_d    = cnt_q + 4'd1;
    decide   = 1'b0;
    case (state_q)
      IDLE:               decide = 1'b1;
      MOVE_UP, MOVE_DOWN: decide = arrive;
      DOOR_OPEN: begin
        if (restart)   cnt_d  = '0;
        else if (hold) cnt_d  = cnt_q;
        else           decide = (cnt_q == DOOR_LAST);
      end
      default: ;
    endcase
    if (decide) begin
      state_d  = decision.st;
      dir_up_d = decision.up;
      cnt_d    = '0;
    end

    // A call for the floor the door is open at is answered, never stored.
    clr       = (state_d == DOOR_OPEN) ? floor_bit(floor_d) : 3'b000;
    pending_d = (pending_q | bus.req) & ~clr;

    case (state_d)
      MOVE_UP:   next_floor_d = floor_d + 2'd1;
      MOVE_DOWN: next_floor_d = floor_d - 2'd1;
      default:   next_floor_d = floor_d;
    endcase
  end

  always_ff @(posedge new_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      floor_q       <= '0;
      next_floor_q  <= '0;
      pending_q     <= '0;
      dir_up_q      <= 1'b1;
      cnt_q         <= '0;
      door_open_q   <= 1'b0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values.
      state_q       <= state_d;
      floor_q       <= floor_d;
      next_floor_q  <= next_floor_d;
      pending_q     <= pending_d;
      dir_up_q      <= dir_up_d;
      cnt_q         <= cnt_d;
      door_open_q   <= (state_d == DOOR_OPEN);
      moving_up_q   <= (state_d == MOVE_UP);
      moving_down_q <= (state_d == MOVE_DOWN);
    end
  end

  assign bus.Disp_1      = {2'b00, floor_q};
  assign bus.Disp_2      = {2'b00, next_floor_q};
  assign bus.pending     = pending_q;
  assign bus.door_open   = door_open_q;
  assign bus.moving_up   = moving_up_q;
  assign bus.moving_down = moving_down_q;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl: spec timeline table, corner sequences, random calls vs a floor-level model.
// Build with ELEV_DOOR_HOLD_EN defined to also exercise door_hold.
module tb_elevator_ctrl;
  localparam int TRAVEL_T = 4;
  localparam int DOOR_T   = 3;
`ifdef ELEV_DOOR_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic new_clock = 1'b0;
  logic rst_n     = 1'b0;
  int   n_checks  = 0;
  int   n_err     = 0;

  elevator_ctrl_if bus ();

  elevator_ctrl #(.TRAVEL_TICKS(TRAVEL_T), .DOOR_TICKS(DOOR_T)) dut (
    .new_clock(new_clock),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 new_clock = ~new_clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: where the car is, what it is doing and how many ticks that activity has left.
  typedef enum {P_IDLE, P_UP, P_DOWN, P_DOOR} phase_t;
  phase_t   m_phase;
  int       m_floor;
  int       m_left;
  bit       m_up;
  bit [2:0] m_pend;

  task automatic model_reset();
    m_phase = P_IDLE;
    m_floor = 0;
    m_left  = 0;
    m_up    = 1'b1;
    m_pend  = 3'b000;
  endtask

  function automatic bit any_side(input bit [2:0] p, input int f, input bit upward);
    for (int g = 0; g < 3; g++)
      if (p[g] && (upward ? g > f : g < f)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_choose(input bit [2:0] p);
    if (p[m_floor]) begin
      m_phase = P_DOOR;
      m_left  = DOOR_T;
    end else if (any_side(p, m_floor, m_up)) begin
      m_phase = m_up ? P_UP : P_DOWN;
      m_left  = TRAVEL_T;
    end else if (any_side(p, m_floor, !m_up)) begin
      m_up    = !m_up;
      m_phase = m_up ? P_UP : P_DOWN;
      m_left  = TRAVEL_T;
    end else begin
      m_phase = P_IDLE;
    end
  endtask

  task automatic model_step(input bit [2:0] r, input bit h);
    bit [2:0] old;
    old = m_pend;
    case (m_phase)
      P_IDLE: model_choose(old);
      P_UP, P_DOWN: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += (m_phase == P_UP) ? 1 : -1;
          model_choose(old);
        end
      end
      default: begin
        if (r[m_floor]) m_left = DOOR_T;
        else if (!(h && HOLD_EN)) begin
          m_left--;
          if (m_left == 0) model_choose(old);
        end
      end
    endcase
    m_pend = old | r;
    if (m_phase == P_DOOR) m_pend[m_floor] = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic compare_model();
    int d2, a, b;
    d2 = (m_phase == P_UP) ? m_floor + 1 : (m_phase == P_DOWN) ? m_floor - 1 : m_floor;
    a  = int'(bus.Disp_1);
    b  = int'(bus.Disp_2);
    check("model_disp1", bus.Disp_1, m_floor);
    check("model_disp2", bus.Disp_2, d2);
    check("model_door", bus.door_open, m_phase == P_DOOR);
    check("model_up", bus.moving_up, m_phase == P_UP);
    check("model_down", bus.moving_down, m_phase == P_DOWN);
    check("model_pending", bus.pending, m_pend);
    check("range", (a <= 2 && b <= 2 && a - b <= 1 && b - a <= 1 &&
                    !(bus.moving_up && bus.moving_down)), 1);
  endtask

  task automatic cycle(input logic [2:0] r, input logic h);
    bus.req = r;
`ifdef ELEV_DOOR_HOLD_EN
    bus.door_hold = h;
`endif
    @(posedge new_clock);
    #1;
    model_step(r, h);
    compare_model();
  endtask

  task automatic do_reset();
    bus.req = 3'b000;
`ifdef ELEV_DOOR_HOLD_EN
    bus.door_hold = 1'b0;
`endif
    rst_n = 1'b0;
    @(posedge new_clock);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic bit cond_hit(input int which);
    case (which)
      0:       return bus.door_open;
      1:       return bus.moving_down;
      2:       return bus.Disp_1 == 4'd1;
      default: return bus.moving_up;
    endcase
  endfunction

  task automatic wait_cond(input int which, input string name);
    for (int i = 0; i < 40 && !cond_hit(which); i++) cycle(3'b000, 1'b0);
    check(name, cond_hit(which), 1);
  endtask

  typedef struct {
    logic [2:0] req;
    int         d1;
    int         d2;
    bit         door;
    bit         up;
    bit         down;
    logic [2:0] pend;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int n;
    bus.req = 3'b000;
`ifdef ELEV_DOOR_HOLD_EN
    bus.door_hold = 1'b0;
`endif
    model_reset();
    // Single call to floor 2, one row per edge starting at edge 0.
    tbl[0]  = '{3'b100, 0, 0, 1'b0, 1'b0, 1'b0, 3'b100};
    tbl[1]  = '{3'b000, 0, 1, 1'b0, 1'b1, 1'b0, 3'b100};
    tbl[2]  = '{3'b000, 0, 1, 1'b0, 1'b1, 1'b0, 3'b100};
    tbl[3]  = '{3'b000, 0, 1, 1'b0, 1'b1, 1'b0, 3'b100};
    tbl[4]  = '{3'b000, 0, 1, 1'b0, 1'b1, 1'b0, 3'b100};
    tbl[5]  = '{3'b000, 1, 2, 1'b0, 1'b1, 1'b0, 3'b100};
    tbl[6]  = '{3'b000, 1, 2, 1'b0, 1'b1, 1'b0, 3'b100};
    tbl[7]  = '{3'b000, 1, 2, 1'b0, 1'b1, 1'b0, 3'b100};
    tbl[8]  = '{3'b000, 1, 2, 1'b0, 1'b1, 1'b0, 3'b100};
    tbl[9]  = '{3'b000, 2, 2, 1'b1, 1'b0, 1'b0, 3'b000};
    tbl[10] = '{3'b000, 2, 2, 1'b1, 1'b0, 1'b0, 3'b000};
    tbl[11] = '{3'b000, 2, 2, 1'b1, 1'b0, 1'b0, 3'b000};
    tbl[12] = '{3'b000, 2, 2, 1'b0, 1'b0, 1'b0, 3'b000};
    tbl[13] = '{3'b000, 2, 2, 1'b0, 1'b0, 1'b0, 3'b000};

    #12;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].req, 1'b0);
      check($sformatf("vec%0d_disp1", i), bus.Disp_1, tbl[i].d1);
      check($sformatf("vec%0d_disp2", i), bus.Disp_2, tbl[i].d2);
      check($sformatf("vec%0d_door", i), bus.door_open, tbl[i].door);
      check($sformatf("vec%0d_up", i), bus.moving_up, tbl[i].up);
      check($sformatf("vec%0d_down", i), bus.moving_down, tbl[i].down);
      check($sformatf("vec%0d_pending", i), bus.pending, tbl[i].pend);
    end

    // Asynchronous reset in the middle of an upward move.
    do_reset();
    cycle(3'b100, 1'b0);
    cycle(3'b010, 1'b0);
    check("pre_reset_moving_up", bus.moving_up, 1);
    rst_n = 1'b0;
    #2;
    check("rst_disp1", bus.Disp_1, 0);
    check("rst_disp2", bus.Disp_2, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_flags", {bus.door_open, bus.moving_up, bus.moving_down}, 0);
    @(posedge new_clock);
    #1;
    rst_n = 1'b1;
    model_reset();

    // SCAN ordering: calls above and below while passing floor 1 upward.
    do_reset();
    cycle(3'b100, 1'b0);
    wait_cond(2, "scan_reach_floor1");
    check("scan_up_at_1", bus.moving_up, 1);
    check("scan_d2_a", bus.Disp_2, 2);
    cycle(3'b101, 1'b0);
    wait_cond(0, "scan_door_2");
    check("scan_door_floor", bus.Disp_1, 2);
    check("scan_d2_b", bus.Disp_2, 2);
    wait_cond(1, "scan_reverse");
    check("scan_d2_c", bus.Disp_2, 1);
    wait_cond(2, "scan_pass_floor1");
    check("scan_down_at_1", bus.moving_down, 1);
    check("scan_d2_d", bus.Disp_2, 0);
    wait_cond(0, "scan_door_0");
    check("scan_final_floor", bus.Disp_1, 0);
    check("scan_final_pending", bus.pending, 0);

    // Call for the floor the idle car is already at, then a re-press during dwell.
    do_reset();
    cycle(3'b001, 1'b0);
    check("here_latched", bus.pending, 3'b001);
    check("here_not_yet_open", bus.door_open, 0);
    cycle(3'b000, 1'b0);
    check("here_open", bus.door_open, 1);
    check("here_cleared", bus.pending, 0);
    n = 1;
    for (int i = 0; i < 10; i++) begin
      cycle(3'b000, 1'b0);
      if (!bus.door_open) break;
      n++;
    end
    check("door_len", n, DOOR_T);

    cycle(3'b001, 1'b0);
    cycle(3'b000, 1'b0);
    check("repress_open", bus.door_open, 1);
    cycle(3'b000, 1'b0);
    cycle(3'b001, 1'b0);
    check("repress_not_latched", bus.pending, 0);
    n = 3;
    for (int i = 0; i < 10; i++) begin
      cycle(3'b000, 1'b0);
      if (!bus.door_open) break;
      n++;
    end
    check("door_restart_len", n, 5);

`ifdef ELEV_DOOR_HOLD_EN
    // Door held for five cycles extends the dwell by five.
    do_reset();
    cycle(3'b001, 1'b0);
    cycle(3'b000, 1'b0);
    n = bus.door_open ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      cycle(3'b000, 1'b1);
      if (bus.door_open) n++;
    end
    for (int i = 0; i < 10; i++) begin
      cycle(3'b000, 1'b0);
      if (!bus.door_open) break;
      n++;
    end
    check("door_hold_len", n, DOOR_T + 5);
`endif

    // Random calls and holds against the model.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      logic [2:0] r;
      logic       h;
      r = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      h = ($urandom_range(0, 7) == 0);
      cycle(r, h);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

- Request-scheduling and car-motion controller for the three-floor elevator.
- Latches floor-call buttons and runs a SCAN (keep-direction) policy, with travel and door-open dwell timed in `new_clock` ticks.
- Publishes current floor (`Disp_1`) and next floor (`Disp_2`) as 4-bit floor codes 0..2.
- Feeds the next-floor LED decoder and seven-segment display stages directly downstream.

## Interface
- `TRAVEL_TICKS`, default 4: `new_clock` cycles per one-floor move; range 1..15.
- `DOOR_TICKS`, default 3: `new_clock` cycles the door stays open; range 1..15.
- `new_clock` input 1: single clock, all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input 3: floor-call buttons, bit i = floor i, level-sampled each edge.
- `Disp_1` output 4: current floor code, always 0..2.
- `Disp_2` output 4: next floor code, always 0..2.
- `door_open` output 1: high while in DOOR_OPEN.
- `moving_up` output 1: high in MOVE_UP.
- `moving_down` output 1: high in MOVE_DOWN.
- `pending` output 3: latched outstanding calls.
- `door_hold` input 1: present only with `ELEV_DOOR_HOLD_EN`.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; internal direction register `dir_up`.
- Reset values: IDLE, `Disp_1`=0, `Disp_2`=0, `pending`=0, `dir_up`=1, all flags 0, counters 0.
- Call latching, every edge: `pending <= (pending | req) & ~clr`.
  - `clr` is the current-floor bit when DOOR_OPEN is entered.
  - A `req` bit for the current floor while in DOOR_OPEN is not latched; it restarts the door counter.
- "Ahead" means a `pending` bit strictly above `Disp_1` when `dir_up`=1, or strictly below when `dir_up`=0. "Behind" is the opposite side.
- Decisions use registered `pending` only.
- IDLE:
  - `pending[Disp_1]` set -> DOOR_OPEN.
  - Else ahead -> move in `dir_up`.
  - Else behind -> flip `dir_up` and move.
  - Else stay.
  - Current floor takes priority over ahead, ahead over behind.
- MOVE_UP / MOVE_DOWN:
  - Travel counter reloads to 0 on entry and counts to `TRAVEL_TICKS`.
  - On the `TRAVEL_TICKS`-th edge in the state, `Disp_1` steps by ±1 and the next state is chosen for the new floor.
  - `pending[new]` -> DOOR_OPEN.
  - Else ahead -> same move state, counter reloads.
  - Else behind -> reverse.
  - Else IDLE.
- DOOR_OPEN:
  - Lasts `DOOR_TICKS` cycles.
  - Exit follows the IDLE priority (ahead, then behind, then IDLE); the current-floor bit is already cleared.
- `Disp_2`: `Disp_1`+1 in MOVE_UP, `Disp_1`-1 in MOVE_DOWN, otherwise `Disp_1`. It is registered, so it updates on the same edge as the state.
- Boundary rules:
  - Never MOVE_UP at floor 2 or MOVE_DOWN at floor 0; the ahead/behind computation guarantees this.
  - `Disp_1` and `Disp_2` never leave 0..2.
- Reset mid-move or mid-door: immediately returns all state to the reset values; calls are lost.

## Timing
- `req` asserted before edge k: `pending` bit visible after edge k, FSM reacts at edge k+1.
- One-floor travel: exactly `TRAVEL_TICKS` cycles in the move state.
- Door dwell: exactly `DOOR_TICKS` cycles.
- A car already at the called floor in IDLE opens its door one edge after the call is latched.

## Configuration
- `ELEV_DOOR_HOLD_EN` defined:
  - `door_hold` port exists.
  - While `door_hold`=1 in DOOR_OPEN, the door counter holds and the state cannot exit.
  - Release resumes the count where it stopped.
- Undefined: the port is absent and the door always closes after `DOOR_TICKS`.

## Test plan
- **Reset state:** assert `rst_n`=0 mid-MOVE_UP -> next sample shows `Disp_1`=0, `Disp_2`=0, `pending`=0, all flags 0, with no clock edge needed.
- **Single call to floor 2:** reset, `req`=3'b100 for one cycle before edge 0 ->
  - edge 1: MOVE_UP, `Disp_2`=1.
  - edge 5: `Disp_1`=1, `Disp_2`=2.
  - edge 9: `Disp_1`=2, `door_open`=1, `pending`=0.
  - edges 9-11: `door_open` high.
  - edge 12: IDLE.
- **SCAN ordering:** at floor 1 moving up, latch `req`=3'b101 -> serves floor 2 first, then reverses to floor 0; `Disp_2` sequence 2, 2, 1, 0.
- **Current-floor call in IDLE:** at floor 0, `req`=3'b001 -> `door_open` one edge after latch, lasting 3 cycles.
  - Same call re-pressed in the 2nd door cycle -> door stays open 3 more cycles.
- **Hold (with `ELEV_DOOR_HOLD_EN`):** `door_hold`=1 for 5 cycles during DOOR_OPEN -> door open for 3+5 cycles total.
- **Range check:** random `req` for 10k cycles -> `Disp_1` and `Disp_2` always in 0..2, `|Disp_2-Disp_1|`<=1, `moving_up`&`moving_down` never both 1.
